// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared constants, FSM state type and helpers for the direct-mapped
// instruction cache (icache) and its line storage (icache_line_array).
//
// Contents:
//   ICACHE_LINE_NUM  default number of cache lines (power of two)
//   ICACHE_OFFSET_W  byte-offset width inside a 16-byte line
//   ICACHE_ADDR_W    fetch/memory address width
//   ICACHE_LINE_W    width of one cache line / one memory line transfer
//   state_t          controller states: IDLE=0, WAIT_MEM=1, RESPOND=2
//   icache_word_sel  picks one 32-bit word out of a 128-bit line
// -----------------------------------------------------------------------------
package icache_pkg;

    localparam int ICACHE_LINE_NUM = 64;
    localparam int ICACHE_OFFSET_W = 4;
    localparam int ICACHE_ADDR_W   = 32;
    localparam int ICACHE_LINE_W   = 128;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        RESPOND  = 2'd2
    } state_t;

    // Byte k of a line lives in bits [8k+7:8k], so word w is bytes 4w..4w+3.
    function automatic logic [31:0] icache_word_sel(
        input logic [ICACHE_LINE_W-1:0] line,
        input logic [1:0]               word
    );
        logic [31:0] w_sel;
        case (word)
            2'd0:    w_sel = line[31:0];
            2'd1:    w_sel = line[63:32];
            2'd2:    w_sel = line[95:64];
            default: w_sel = line[127:96];
        endcase
        return w_sel;
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// -----------------------------------------------------------------------------
// icache_line_array
// Valid / tag / data storage for the direct-mapped instruction cache.
// One combinational read port addressed by index and one synchronous write
// port. Only the valid bits are reset; tag and data contents are qualified
// by the valid bit and therefore need no reset.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset, clears all valid bits
//   i_rd_idx   in   read index
//   o_rd_valid out  valid bit of the indexed line
//   o_rd_tag   out  tag of the indexed line
//   o_rd_data  out  128-bit data of the indexed line
//   i_we       in   write enable (one line per cycle)
//   i_wr_idx   in   write index
//   i_wr_tag   in   tag to store
//   i_wr_data  in   line data to store; valid bit is set with it
// -----------------------------------------------------------------------------
module icache_line_array
    import icache_pkg::*;
#(
    parameter int LINE_NUM = ICACHE_LINE_NUM,
    parameter int INDEX_W  = $clog2(LINE_NUM),
    parameter int TAG_W    = ICACHE_ADDR_W - ICACHE_OFFSET_W - INDEX_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INDEX_W-1:0]       i_rd_idx,
    output logic                     o_rd_valid,
    output logic [TAG_W-1:0]         o_rd_tag,
    output logic [ICACHE_LINE_W-1:0] o_rd_data,
    input  logic                     i_we,
    input  logic [INDEX_W-1:0]       i_wr_idx,
    input  logic [TAG_W-1:0]         i_wr_tag,
    input  logic [ICACHE_LINE_W-1:0] i_wr_data
);

    logic [LINE_NUM-1:0]      r_valid;
    logic [TAG_W-1:0]         r_tag  [LINE_NUM];
    logic [ICACHE_LINE_W-1:0] r_data [LINE_NUM];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/icache.sv
// -----------------------------------------------------------------------------
// icache
// Direct-mapped, read-only instruction cache between the instruction fetcher
// and the memory controller. Hits answer one cycle after acceptance; misses
// fetch a whole 16-byte line, write it, then answer. A pipeline flush cancels
// the pending fetcher response, but an in-flight line fill always completes
// and is written into the array.
//
// Optional feature (macro ICACHE_STATS_EN): adds 32-bit hit_count and
// miss_count outputs counting evaluated (non-flushed) requests.
//
// Ports:
//   clk                    in   clock
//   rst                    in   synchronous active-high reset
//   rdy                    in   global enable; low freezes all state/outputs
//   flush                  in   pipeline flush
//   addr_from_fetcher      in   instruction byte address
//   valid_from_fetcher     in   fetch request (held until ready_to_fetcher)
//   inst_to_fetcher        out  instruction word
//   ready_to_fetcher       out  one-cycle response pulse
//   addr_to_mem_ctrler     out  line address (low 4 bits zero)
//   valid_to_mem_ctrler    out  line-fill request
//   data_from_mem_ctrler   in   128-bit line, byte k at [8k+7:8k]
//   ready_from_mem_ctrler  in   one-cycle fill-data pulse
//   hit_count              out  (ICACHE_STATS_EN only) hit counter
//   miss_count             out  (ICACHE_STATS_EN only) miss counter
// -----------------------------------------------------------------------------
module icache
    import icache_pkg::*;
#(
    parameter int LINE_NUM = ICACHE_LINE_NUM
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     flush,
    input  logic [ICACHE_ADDR_W-1:0] addr_from_fetcher,
    input  logic                     valid_from_fetcher,
    output logic [31:0]              inst_to_fetcher,
    output logic                     ready_to_fetcher,
    output logic [ICACHE_ADDR_W-1:0] addr_to_mem_ctrler,
    output logic                     valid_to_mem_ctrler,
    input  logic [ICACHE_LINE_W-1:0] data_from_mem_ctrler,
    input  logic                     ready_from_mem_ctrler
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count
`endif
);

    localparam int INDEX_W = $clog2(LINE_NUM);
    localparam int TAG_W   = ICACHE_ADDR_W - ICACHE_OFFSET_W - INDEX_W;

    // Request address split
    logic [TAG_W-1:0]   w_req_tag;
    logic [INDEX_W-1:0] w_req_idx;
    logic [1:0]         w_req_word;
    logic [1:0]         w_unused_byte_sel;

    assign w_req_tag         = addr_from_fetcher[ICACHE_ADDR_W-1 -: TAG_W];
    assign w_req_idx         = addr_from_fetcher[ICACHE_OFFSET_W +: INDEX_W];
    assign w_req_word        = addr_from_fetcher[3:2];
    assign w_unused_byte_sel = addr_from_fetcher[1:0];

    // Controller state and latched miss request
    state_t             r_state;
    logic [TAG_W-1:0]   r_tag;
    logic [INDEX_W-1:0] r_idx;
    logic [1:0]         r_word;
    logic               r_cancel;

    // Array interface
    logic [INDEX_W-1:0]       w_rd_idx;
    logic                     w_rd_valid;
    logic [TAG_W-1:0]         w_rd_tag;
    logic [ICACHE_LINE_W-1:0] w_rd_data;
    logic                     w_we;
    logic                     w_hit;
    logic                     w_eval;
    logic                     w_fill;

    // In IDLE the array is looked up with the live request; in RESPOND it
    // supplies the word of the line that was just written.
    assign w_rd_idx = (r_state == IDLE) ? w_req_idx : r_idx;
    assign w_hit    = w_rd_valid && (w_rd_tag == w_req_tag);

    // A request is evaluated only when no response is on the bus this cycle
    // and no flush is cancelling it.
    assign w_eval = (r_state == IDLE) && valid_from_fetcher &&
                    !ready_to_fetcher && !flush;

    assign w_fill = (r_state == WAIT_MEM) && ready_from_mem_ctrler;
    assign w_we   = rdy && !rst && w_fill;

    icache_line_array #(
        .LINE_NUM (LINE_NUM),
        .INDEX_W  (INDEX_W),
        .TAG_W    (TAG_W)
    ) u_line_array (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (w_rd_idx),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_we       (w_we),
        .i_wr_idx   (r_idx),
        .i_wr_tag   (r_tag),
        .i_wr_data  (data_from_mem_ctrler)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state             <= IDLE;
            r_tag               <= '0;
            r_idx               <= '0;
            r_word              <= '0;
            r_cancel            <= 1'b0;
            inst_to_fetcher     <= '0;
            ready_to_fetcher    <= 1'b0;
            addr_to_mem_ctrler  <= '0;
            valid_to_mem_ctrler <= 1'b0;
        end else if (rdy) begin
            case (r_state)
                IDLE: begin
                    ready_to_fetcher <= 1'b0;
                    if (w_eval) begin
                        if (w_hit) begin
                            ready_to_fetcher <= 1'b1;
                            inst_to_fetcher  <= icache_word_sel(w_rd_data, w_req_word);
                        end else begin
                            r_tag               <= w_req_tag;
                            r_idx               <= w_req_idx;
                            r_word              <= w_req_word;
                            r_cancel            <= 1'b0;
                            valid_to_mem_ctrler <= 1'b1;
                            addr_to_mem_ctrler  <= {w_req_tag, w_req_idx,
                                                    {ICACHE_OFFSET_W{1'b0}}};
                            r_state             <= WAIT_MEM;
                        end
                    end
                end

                WAIT_MEM: begin
                    if (ready_from_mem_ctrler) begin
                        // Line is written by the array this edge; a flush seen
                        // now or earlier skips the response entirely.
                        valid_to_mem_ctrler <= 1'b0;
                        r_state <= (r_cancel || flush) ? IDLE : RESPOND;
                    end else if (flush) begin
                        r_cancel <= 1'b1;
                    end
                end

                RESPOND: begin
                    r_state <= IDLE;
                    if (!flush && !r_cancel) begin
                        ready_to_fetcher <= 1'b1;
                        inst_to_fetcher  <= icache_word_sel(w_rd_data, r_word);
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (rdy && w_eval) begin
            if (w_hit) begin
                hit_count <= hit_count + 32'd1;
            end else begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache.sv
module tb_icache;

    logic         clk;
    logic         rst;
    logic         rdy;
    logic         flush;
    logic [31:0]  addr_from_fetcher;
    logic         valid_from_fetcher;
    logic [31:0]  inst_to_fetcher;
    logic         ready_to_fetcher;
    logic [31:0]  addr_to_mem_ctrler;
    logic         valid_to_mem_ctrler;
    logic [127:0] data_from_mem_ctrler;
    logic         ready_from_mem_ctrler;
`ifdef ICACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    int checks = 0;
    int errors = 0;

    icache dut (
        .clk                   (clk),
        .rst                   (rst),
        .rdy                   (rdy),
        .flush                 (flush),
        .addr_from_fetcher     (addr_from_fetcher),
        .valid_from_fetcher    (valid_from_fetcher),
        .inst_to_fetcher       (inst_to_fetcher),
        .ready_to_fetcher      (ready_to_fetcher),
        .addr_to_mem_ctrler    (addr_to_mem_ctrler),
        .valid_to_mem_ctrler   (valid_to_mem_ctrler),
        .data_from_mem_ctrler  (data_from_mem_ctrler),
        .ready_from_mem_ctrler (ready_from_mem_ctrler)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count             (hit_count),
        .miss_count            (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: word w of line la is la+w, except line 0x1000 word 1.
    function automatic logic [127:0] mk_line(input logic [31:0] la);
        logic [31:0] w1;
        w1 = (la == 32'h0000_1000) ? 32'h0051_0113 : la + 32'd1;
        return {la + 32'd3, la + 32'd2, w1, la};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Full request: on a miss, serve the line one cycle after seeing the request.
    task automatic fetch(input logic [31:0] a, input bit exp_miss,
                         input logic [31:0] exp_inst, input string nm);
        valid_from_fetcher = 1'b1;
        addr_from_fetcher  = a;
        step();
        if (exp_miss) begin
            chk1 ({nm, "_memreq"}, valid_to_mem_ctrler, 1'b1);
            chk32({nm, "_memaddr"}, addr_to_mem_ctrler, a & 32'hFFFF_FFF0);
            chk1 ({nm, "_early_rdy"}, ready_to_fetcher, 1'b0);
            step();
            chk1 ({nm, "_memreq_held"}, valid_to_mem_ctrler, 1'b1);
            data_from_mem_ctrler  = mk_line(a & 32'hFFFF_FFF0);
            ready_from_mem_ctrler = 1'b1;
            step();
            ready_from_mem_ctrler = 1'b0;
            chk1 ({nm, "_memreq_drop"}, valid_to_mem_ctrler, 1'b0);
            chk1 ({nm, "_rdy_fill_cycle"}, ready_to_fetcher, 1'b0);
            step();
        end else begin
            chk1({nm, "_no_memreq"}, valid_to_mem_ctrler, 1'b0);
        end
        chk1 ({nm, "_rdy"}, ready_to_fetcher, 1'b1);
        chk32({nm, "_inst"}, inst_to_fetcher, exp_inst);
        valid_from_fetcher = 1'b0;
        step();
        chk1 ({nm, "_rdy_pulse"}, ready_to_fetcher, 1'b0);
    endtask

    typedef struct {
        logic [31:0] addr;
        bit          miss;
        logic [31:0] inst;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{32'h0000_1004, 1'b1, 32'h0051_0113}; // cold miss
        tbl[1] = '{32'h0000_1008, 1'b0, 32'h0000_1002}; // refetch hit, word2
        tbl[2] = '{32'h0000_1000, 1'b0, 32'h0000_1000};
        tbl[3] = '{32'h0000_1400, 1'b1, 32'h0000_1400}; // conflict, index 0
        tbl[4] = '{32'h0000_1000, 1'b1, 32'h0000_1000}; // evicted, misses again
        tbl[5] = '{32'h0000_140C, 1'b1, 32'h0000_1403};
        tbl[6] = '{32'h0000_140E, 1'b0, 32'h0000_1403}; // addr[1:0] ignored
        tbl[7] = '{32'h0000_2010, 1'b1, 32'h0000_2010}; // index 1
        tbl[8] = '{32'h0000_1404, 1'b0, 32'h0000_1401};
        tbl[9] = '{32'h0000_2014, 1'b0, 32'h0000_2011};

        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        addr_from_fetcher = '0; valid_from_fetcher = 1'b0;
        data_from_mem_ctrler = '0; ready_from_mem_ctrler = 1'b0;
        step(); step();
        chk1 ("reset_rdy", ready_to_fetcher, 1'b0);
        chk1 ("reset_memreq", valid_to_mem_ctrler, 1'b0);
        chk32("reset_memaddr", addr_to_mem_ctrler, 32'h0);
        chk32("reset_inst", inst_to_fetcher, 32'h0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 10; i++) begin
            fetch(tbl[i].addr, tbl[i].miss, tbl[i].inst, $sformatf("vec%0d", i));
        end

        // Flush during WAIT_MEM: fill completes, no response, line is written.
        valid_from_fetcher = 1'b1; addr_from_fetcher = 32'h0000_3024;
        step();
        chk1("fwait_memreq", valid_to_mem_ctrler, 1'b1);
        flush = 1'b1; valid_from_fetcher = 1'b0;
        step();
        flush = 1'b0;
        chk1("fwait_memreq_held", valid_to_mem_ctrler, 1'b1);
        data_from_mem_ctrler = mk_line(32'h0000_3020); ready_from_mem_ctrler = 1'b1;
        step();
        ready_from_mem_ctrler = 1'b0;
        chk1("fwait_memreq_drop", valid_to_mem_ctrler, 1'b0);
        chk1("fwait_no_rdy0", ready_to_fetcher, 1'b0);
        step();
        chk1("fwait_no_rdy1", ready_to_fetcher, 1'b0);
        fetch(32'h0000_3024, 1'b0, 32'h0000_3021, "fwait_refetch");

        // Flush in the same cycle as the fill pulse.
        valid_from_fetcher = 1'b1; addr_from_fetcher = 32'h0000_3030;
        step();
        chk1("ffill_memreq", valid_to_mem_ctrler, 1'b1);
        data_from_mem_ctrler = mk_line(32'h0000_3030); ready_from_mem_ctrler = 1'b1;
        flush = 1'b1; valid_from_fetcher = 1'b0;
        step();
        ready_from_mem_ctrler = 1'b0; flush = 1'b0;
        chk1("ffill_no_rdy0", ready_to_fetcher, 1'b0);
        step();
        chk1("ffill_no_rdy1", ready_to_fetcher, 1'b0);
        fetch(32'h0000_3038, 1'b0, 32'h0000_3032, "ffill_refetch");

        // Flush in IDLE suppresses a hit.
        valid_from_fetcher = 1'b1; addr_from_fetcher = 32'h0000_2014; flush = 1'b1;
        step();
        flush = 1'b0; valid_from_fetcher = 1'b0;
        chk1("fidle_no_rdy", ready_to_fetcher, 1'b0);
        chk1("fidle_no_memreq", valid_to_mem_ctrler, 1'b0);
        step();

        // Flush in RESPOND.
        valid_from_fetcher = 1'b1; addr_from_fetcher = 32'h0000_3040;
        step();
        chk1("fresp_memreq", valid_to_mem_ctrler, 1'b1);
        data_from_mem_ctrler = mk_line(32'h0000_3040); ready_from_mem_ctrler = 1'b1;
        step();
        ready_from_mem_ctrler = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0; valid_from_fetcher = 1'b0;
        chk1("fresp_no_rdy0", ready_to_fetcher, 1'b0);
        step();
        chk1("fresp_no_rdy1", ready_to_fetcher, 1'b0);
        fetch(32'h0000_3040, 1'b0, 32'h0000_3040, "fresp_refetch");

        // rdy low in WAIT_MEM and in RESPOND: everything frozen.
        valid_from_fetcher = 1'b1; addr_from_fetcher = 32'h0000_3050;
        step();
        chk1("stall_memreq", valid_to_mem_ctrler, 1'b1);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk1 ($sformatf("stall_wait_memreq%0d", i), valid_to_mem_ctrler, 1'b1);
            chk32($sformatf("stall_wait_addr%0d", i), addr_to_mem_ctrler, 32'h0000_3050);
            chk1 ($sformatf("stall_wait_rdy%0d", i), ready_to_fetcher, 1'b0);
        end
        rdy = 1'b1;
        data_from_mem_ctrler = mk_line(32'h0000_3050); ready_from_mem_ctrler = 1'b1;
        step();
        ready_from_mem_ctrler = 1'b0; rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk1($sformatf("stall_resp_rdy%0d", i), ready_to_fetcher, 1'b0);
            chk1($sformatf("stall_resp_memreq%0d", i), valid_to_mem_ctrler, 1'b0);
        end
        rdy = 1'b1;
        step();
        chk1 ("stall_rdy", ready_to_fetcher, 1'b1);
        chk32("stall_inst", inst_to_fetcher, 32'h0000_3050);
        valid_from_fetcher = 1'b0;
        step();
        chk1("stall_once0", ready_to_fetcher, 1'b0);
        step();
        chk1("stall_once1", ready_to_fetcher, 1'b0);

        // rdy low while a hit pulse is on the bus: pulse is held.
        valid_from_fetcher = 1'b1; addr_from_fetcher = 32'h0000_3054;
        step();
        chk1("hold_rdy", ready_to_fetcher, 1'b1);
        rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk1 ($sformatf("hold_rdy%0d", i), ready_to_fetcher, 1'b1);
            chk32($sformatf("hold_inst%0d", i), inst_to_fetcher, 32'h0000_3051);
        end
        rdy = 1'b1; valid_from_fetcher = 1'b0;
        step();
        chk1("hold_release", ready_to_fetcher, 1'b0);

        // Reset mid-fill: a late fill pulse is ignored, line stays invalid.
        valid_from_fetcher = 1'b1; addr_from_fetcher = 32'h0000_3060;
        step();
        chk1("rstfill_memreq", valid_to_mem_ctrler, 1'b1);
        rst = 1'b1; valid_from_fetcher = 1'b0;
        step();
        rst = 1'b0;
        chk1 ("rstfill_memreq_clr", valid_to_mem_ctrler, 1'b0);
        chk32("rstfill_addr_clr", addr_to_mem_ctrler, 32'h0);
        data_from_mem_ctrler = mk_line(32'h0000_3060); ready_from_mem_ctrler = 1'b1;
        step();
        ready_from_mem_ctrler = 1'b0;
        chk1("rstfill_no_rdy0", ready_to_fetcher, 1'b0);
        step();
        chk1("rstfill_no_rdy1", ready_to_fetcher, 1'b0);
        fetch(32'h0000_3060, 1'b1, 32'h0000_3060, "rstfill_refetch");

        // Fresh reset, then miss, hit, hit, flushed request.
        rst = 1'b1;
        step();
        chk1("reset2_rdy", ready_to_fetcher, 1'b0);
        chk1("reset2_memreq", valid_to_mem_ctrler, 1'b0);
`ifdef ICACHE_STATS_EN
        chk32("reset_hits", hit_count, 32'd0);
        chk32("reset_misses", miss_count, 32'd0);
`endif
        rst = 1'b0;
        step();
        fetch(32'h0000_1004, 1'b1, 32'h0051_0113, "st_miss");
        fetch(32'h0000_1008, 1'b0, 32'h0000_1002, "st_hit0");
        fetch(32'h0000_100C, 1'b0, 32'h0000_1003, "st_hit1");
        valid_from_fetcher = 1'b1; addr_from_fetcher = 32'h0000_1000; flush = 1'b1;
        step();
        flush = 1'b0; valid_from_fetcher = 1'b0;
        chk1("st_flushed_no_rdy", ready_to_fetcher, 1'b0);
        step();
`ifdef ICACHE_STATS_EN
        chk32("stats_hits", hit_count, 32'd2);
        chk32("stats_misses", miss_count, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
